// File: rtl/readout_pkg.sv
// Shared constants and state encoding for the column readout arbiter.
package readout_pkg;

  localparam int DEF_N_PIX   = 8;
  localparam int DEF_ADDR_W  = 3;
  localparam int DEF_DATA_W  = 16;
  localparam int GRANT_CNT_W = 16;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/rr_priority_picker.sv
// Rotating priority encoder: first set request at or above ptr, wrapping modulo N.
module rr_priority_picker #(
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [AW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [AW-1:0] grant_idx
);

  logic [AW-1:0] idx;

  // Scan from farthest to nearest offset so the nearest hit is written last.
  // N is a power of two, so AW-bit addition wraps modulo N for free.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = ptr + AW'(k);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/column_readout_arbiter.sv
// Round-robin column readout arbiter: grants one pixel at a time, captures its
// address and counter, and holds the word until the serializer takes it.
module column_readout_arbiter
  import readout_pkg::*;
#(
  parameter int N_PIX  = DEF_N_PIX,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int CNT_W  = GRANT_CNT_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [N_PIX-1:0]        req,
  input  logic [N_PIX*DATA_W-1:0] pix_data,
  output logic [N_PIX-1:0]        ack,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ADDR_W-1:0]       out_addr,
  output logic [DATA_W-1:0]       out_data,
  output logic                    busy,
  input  logic                    clr_cnt,
  output logic [CNT_W-1:0]        grant_cnt,
  output state_t                  state_dbg
);

  state_t              state;
  logic [ADDR_W-1:0]   ptr;
  logic [N_PIX-1:0]    grant;
  logic [ADDR_W-1:0]   grant_idx;
  logic [DATA_W-1:0]   sel_data;
  logic                xfer;

  rr_priority_picker #(
    .N  (N_PIX),
    .AW (ADDR_W)
  ) u_picker (
    .req       (req),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    sel_data = '0;
    for (int i = 0; i < N_PIX; i++) begin
      if (grant_idx == ADDR_W'(i)) sel_data = pix_data[i*DATA_W +: DATA_W];
    end
  end

  // Output handshake: a word moves on any edge where out_valid and out_ready
  // are both high; until then out_valid/out_addr/out_data hold unchanged, and
  // out_valid never drops without that transfer (except by rst).
  assign xfer      = (state == SEND) && out_valid && out_ready;
  assign busy      = (state != IDLE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ack       <= '0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
      ptr       <= '0;
    end else begin
      ack <= '0;
      case (state)
        IDLE: begin
          if (en && |req) begin
            ack       <= grant;
            out_valid <= 1'b1;
            out_addr  <= grant_idx;
            out_data  <= sel_data;
            ptr       <= grant_idx + 1'b1;
            state     <= SEND;
          end
        end
        SEND: begin
          if (xfer) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Clear beats a simultaneous transfer; the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || clr_cnt) begin
      grant_cnt <= '0;
    end else if (xfer && (grant_cnt != {CNT_W{1'b1}})) begin
      grant_cnt <= grant_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_column_readout_arbiter.sv
// Directed bench for column_readout_arbiter; a 2-bit-counter copy shares the stimulus.
module tb_column_readout_arbiter;
  import readout_pkg::*;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int DW = 16;

  logic              clk;
  logic              rst;
  logic              en;
  logic [N-1:0]      req;
  logic [N*DW-1:0]   pix_data;
  logic              out_ready;
  logic              clr_cnt;

  logic [N-1:0]      ack;
  logic              out_valid;
  logic [AW-1:0]     out_addr;
  logic [DW-1:0]     out_data;
  logic              busy;
  logic [15:0]       grant_cnt;
  state_t            st;

  logic [N-1:0]      s_ack;
  logic              s_out_valid;
  logic [AW-1:0]     s_out_addr;
  logic [DW-1:0]     s_out_data;
  logic              s_busy;
  logic [1:0]        s_grant_cnt;
  state_t            s_st;

  int total;
  int passed;

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  column_readout_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .pix_data  (pix_data),
    .ack       (ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_data  (out_data),
    .busy      (busy),
    .clr_cnt   (clr_cnt),
    .grant_cnt (grant_cnt),
    .state_dbg (st)
  );

  column_readout_arbiter #(.CNT_W(2)) dut_sat (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .req       (req),
    .pix_data  (pix_data),
    .ack       (s_ack),
    .out_valid (s_out_valid),
    .out_ready (out_ready),
    .out_addr  (s_out_addr),
    .out_data  (s_out_data),
    .busy      (s_busy),
    .clr_cnt   (clr_cnt),
    .grant_cnt (s_grant_cnt),
    .state_dbg (s_st)
  );

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_pix(input int i, input logic [DW-1:0] v);
    pix_data[i*DW +: DW] = v;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_word(input string tag, input int a, input logic [DW-1:0] d);
    chk({tag, "_valid"}, 32'(out_valid), 32'd1);
    chk({tag, "_addr"},  32'(out_addr),  32'(a));
    chk({tag, "_ack"},   32'(ack),       32'(8'd1 << a));
    chk({tag, "_data"},  32'(out_data),  32'(d));
    chk({tag, "_busy"},  32'(busy),      32'd1);
  endtask

  initial begin
    int exp_cnt;
    total = 0;
    passed = 0;
    rst = 1'b1;
    en = 1'b0;
    req = '0;
    out_ready = 1'b0;
    clr_cnt = 1'b0;
    for (int i = 0; i < N; i++) set_pix(i, 16'hA000 + 16'(i));
    tick(2);

    // reset state
    chk("rst_ack",   32'(ack),       32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr",  32'(out_addr),  32'd0);
    chk("rst_data",  32'(out_data),  32'd0);
    chk("rst_busy",  32'(busy),      32'd0);
    chk("rst_cnt",   32'(grant_cnt), 32'd0);
    chk("rst_state", 32'(st),        32'(IDLE));
    rst = 1'b0;

    // round robin: all requests held, ready high
    en = 1'b1;
    req = 8'hFF;
    out_ready = 1'b1;
    for (int w = 0; w < 9; w++) begin
      tick(1);
      chk_word("rr", w % 8, 16'hA000 + 16'(w % 8));
      chk("rr_state", 32'(st), 32'(SEND));
      tick(1);
      chk("rr_gap_valid", 32'(out_valid),   32'd0);
      chk("rr_gap_ack",   32'(ack),         32'd0);
      chk("rr_cnt",       32'(grant_cnt),   32'(w + 1));
      chk("rr_sat_cnt",   32'(s_grant_cnt), 32'((w + 1 > 3) ? 3 : w + 1));
    end
    exp_cnt = 9;

    // backpressure on pixel 5 (pointer is 1)
    req = 8'b0010_0000;
    set_pix(5, 16'h1234);
    out_ready = 1'b0;
    tick(1);
    chk_word("bp_grant", 5, 16'h1234);
    req = '0;
    set_pix(5, 16'hFFFF);
    for (int c = 0; c < 5; c++) begin
      tick(1);
      chk("bp_valid", 32'(out_valid), 32'd1);
      chk("bp_data",  32'(out_data),  32'h1234);
      chk("bp_ack",   32'(ack),       32'd0);
      chk("bp_cnt",   32'(grant_cnt), 32'(exp_cnt));
    end
    out_ready = 1'b1;
    tick(1);
    exp_cnt++;
    chk("bp_done_valid", 32'(out_valid), 32'd0);
    chk("bp_done_cnt",   32'(grant_cnt), 32'(exp_cnt));

    // wrap and skip from pointer 6
    req = 8'b0000_0101;
    tick(1);
    chk_word("wrap0", 0, 16'hA000);
    req = 8'b0000_0100;
    tick(1);
    exp_cnt++;
    chk("wrap0_cnt", 32'(grant_cnt), 32'(exp_cnt));
    tick(1);
    chk_word("wrap2", 2, 16'hA002);
    req = '0;
    tick(1);
    exp_cnt++;
    req = 8'b1000_1100;
    tick(1);
    chk_word("ptr3", 3, 16'hA003);
    req = '0;
    tick(1);
    exp_cnt++;
    chk("ptr3_cnt", 32'(grant_cnt), 32'(exp_cnt));

    // enable gating, then drop en mid-SEND (pointer is 4)
    en = 1'b0;
    req = 8'h01;
    tick(1);
    chk("en0_ack",  32'(ack),  32'd0);
    chk("en0_busy", 32'(busy), 32'd0);
    tick(1);
    chk("en0_valid", 32'(out_valid), 32'd0);
    en = 1'b1;
    tick(1);
    chk_word("en1", 0, 16'hA000);
    en = 1'b0;
    out_ready = 1'b0;
    tick(1);
    chk("endrop_valid", 32'(out_valid), 32'd1);
    chk("endrop_busy",  32'(busy),      32'd1);
    out_ready = 1'b1;
    tick(1);
    exp_cnt++;
    chk("endrop_xfer_valid", 32'(out_valid), 32'd0);
    chk("endrop_cnt",        32'(grant_cnt), 32'(exp_cnt));
    tick(1);
    chk("endrop_nogrant_ack",  32'(ack),  32'd0);
    chk("endrop_nogrant_busy", 32'(busy), 32'd0);
    tick(1);
    chk("endrop_nogrant_valid", 32'(out_valid), 32'd0);

    // reset mid-SEND (pointer is 1)
    en = 1'b1;
    req = 8'h02;
    out_ready = 1'b0;
    tick(1);
    chk_word("prerst", 1, 16'hA001);
    req = '0;
    rst = 1'b1;
    tick(1);
    chk("midrst_valid", 32'(out_valid),   32'd0);
    chk("midrst_busy",  32'(busy),        32'd0);
    chk("midrst_cnt",   32'(grant_cnt),   32'd0);
    chk("midrst_ack",   32'(ack),         32'd0);
    chk("midrst_addr",  32'(out_addr),    32'd0);
    chk("midrst_data",  32'(out_data),    32'd0);
    chk("midrst_scnt",  32'(s_grant_cnt), 32'd0);
    rst = 1'b0;
    req = 8'h82;
    out_ready = 1'b1;
    tick(1);
    chk_word("postrst_ptr0", 1, 16'hA001);
    req = 8'h80;
    tick(1);
    tick(1);
    chk_word("postrst_p7", 7, 16'hA007);
    req = '0;
    tick(1);
    chk("postrst_cnt",  32'(grant_cnt),   32'd2);
    chk("postrst_scnt", 32'(s_grant_cnt), 32'd2);

    // counter saturation on the 2-bit copy (2 = max-1), then clear vs transfer
    for (int t = 0; t < 2; t++) begin
      req = 8'h01;
      tick(1);
      chk_word("sat_grant", 0, 16'hA000);
      req = '0;
      tick(1);
      chk("sat_cnt",  32'(grant_cnt),   32'(3 + t));
      chk("sat_scnt", 32'(s_grant_cnt), 32'd3);
    end
    req = 8'h01;
    tick(1);
    chk_word("clr_grant", 0, 16'hA000);
    req = '0;
    clr_cnt = 1'b1;
    tick(1);
    chk("clr_valid", 32'(out_valid),   32'd0);
    chk("clr_cnt",   32'(grant_cnt),   32'd0);
    chk("clr_scnt",  32'(s_grant_cnt), 32'd0);
    clr_cnt = 1'b0;
    tick(1);
    chk("clr_hold", 32'(grant_cnt), 32'd0);

    // final report
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
